// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 unpack/align front end.
package fp_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned SIG_W     = 24;
  localparam int unsigned ALIGN_W   = 27;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned EXP_MAX   = 255;
  localparam int unsigned ALIGN_CAP = 26;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational per-operand classifier for binary32 values.
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t op,
  output logic  nan_c,
  output logic  snan_c,
  output logic  inf_c,
  output logic  zero_c,
  output logic  subnormal_c
);

  logic exp_max;
  logic exp_zero;
  logic frac_zero;

  assign exp_max   = (op.exp == EXP_W'(EXP_MAX));
  assign exp_zero  = (op.exp == '0);
  assign frac_zero = (op.frac == '0);

  assign nan_c       = exp_max & ~frac_zero;
  // Signalling NaNs have the quiet bit (MSB of the fraction) clear.
  assign snan_c      = nan_c & ~op.frac[FRAC_W-1];
  assign inf_c       = exp_max & frac_zero;
  assign zero_c      = exp_zero & frac_zero;
  assign subnormal_c = exp_zero & ~frac_zero;

endmodule

// File: rtl/fp_unpack_align_r4.sv
// Unpacks two binary32 operands, orders them by magnitude and aligns the
// smaller significand two bits per cycle with a sticky bit.
module fp_unpack_align_r4
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign1,
  output logic               sign2,
  output logic               nan,
  output logic               invalid,
  output logic               inf1,
  output logic               inf2,
  output logic               swapped,
  output logic               sign_big,
  output logic [EXP_W-1:0]   exp_big,
  output logic [SIG_W-1:0]   mant_big,
  output logic [ALIGN_W-1:0] mant_small
);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] n;

  fp32_t fa;
  fp32_t fb;
  assign fa = fp32_t'(op_a);
  assign fb = fp32_t'(op_b);

  logic a_nan, a_snan, a_inf, a_zero, a_sub;
  logic b_nan, b_snan, b_inf, b_zero, b_sub;

  fp_classify u_class_a (
    .op          (fa),
    .nan_c       (a_nan),
    .snan_c      (a_snan),
    .inf_c       (a_inf),
    .zero_c      (a_zero),
    .subnormal_c (a_sub)
  );

  fp_classify u_class_b (
    .op          (fb),
    .nan_c       (b_nan),
    .snan_c      (b_snan),
    .inf_c       (b_inf),
    .zero_c      (b_zero),
    .subnormal_c (b_sub)
  );

  // Unpacked operand fields prior to ordering.
  logic [EXP_W-1:0] exp_a_c;
  logic [EXP_W-1:0] exp_b_c;
  logic [SIG_W-1:0] sig_a_c;
  logic [SIG_W-1:0] sig_b_c;

  assign exp_a_c = (a_zero | a_sub) ? EXP_W'(1) : fa.exp;
  assign exp_b_c = (b_zero | b_sub) ? EXP_W'(1) : fb.exp;
  assign sig_a_c = {~(a_zero | a_sub), fa.frac};
  assign sig_b_c = {~(b_zero | b_sub), fb.frac};

  logic             sign2_c;
  logic             swap_c;
  logic             nan_c;
  logic             inf1_c;
  logic             inf2_c;
  logic             invalid_c;
  logic [EXP_W-1:0] exp_big_c;
  logic [EXP_W-1:0] exp_small_c;
  logic [SIG_W-1:0] sig_big_c;
  logic [SIG_W-1:0] sig_small_c;
  logic [EXP_W-1:0] diff_c;
  logic [CNT_W-1:0] n_init_c;

  assign sign2_c   = fb.sign ^ sub;
  // Ties keep op_a as the larger operand.
  assign swap_c    = {fb.exp, fb.frac} > {fa.exp, fa.frac};
  assign nan_c     = a_nan | b_nan;
  assign inf1_c    = a_inf;
  assign inf2_c    = b_inf;
  assign invalid_c = a_snan | b_snan | (a_inf & b_inf & (fa.sign != sign2_c));

  assign exp_big_c   = swap_c ? exp_b_c : exp_a_c;
  assign exp_small_c = swap_c ? exp_a_c : exp_b_c;
  assign sig_big_c   = swap_c ? sig_b_c : sig_a_c;
  assign sig_small_c = swap_c ? sig_a_c : sig_b_c;

  assign diff_c   = exp_big_c - exp_small_c;
  assign n_init_c = (diff_c >= EXP_W'(ALIGN_CAP)) ? CNT_W'(ALIGN_CAP) : CNT_W'(diff_c);

  logic accept_c;
  logic direct_done_c;
  assign accept_c      = in_valid & in_ready;
  assign direct_done_c = nan_c | inf1_c | inf2_c | (n_init_c == '0);

  // One radix-4 alignment step: shift by two while possible, fold lost bits into sticky.
  logic [1:0]         step_c;
  logic [CNT_W-1:0]   n_after_c;
  logic [ALIGN_W-1:0] shift_c;

  assign step_c    = (n >= CNT_W'(2)) ? 2'd2 : 2'd1;
  assign n_after_c = n - CNT_W'(step_c);

  always_comb begin
    shift_c = mant_small;
    if (step_c == 2'd2) begin
      shift_c = {2'b00, mant_small[ALIGN_W-1:2]} | {{(ALIGN_W-1){1'b0}}, |mant_small[1:0]};
    end else begin
      shift_c = {1'b0, mant_small[ALIGN_W-1:1]} | {{(ALIGN_W-1){1'b0}}, mant_small[0]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = direct_done_c ? DONE : ALIGN;
        end
      end
      ALIGN: begin
        if (n_after_c == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand capture on acceptance, then in-place alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n          <= '0;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      nan        <= 1'b0;
      invalid    <= 1'b0;
      inf1       <= 1'b0;
      inf2       <= 1'b0;
      swapped    <= 1'b0;
      sign_big   <= 1'b0;
      exp_big    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
    end else if (accept_c) begin
      n          <= n_init_c;
      sign1      <= fa.sign;
      sign2      <= sign2_c;
      nan        <= nan_c;
      invalid    <= invalid_c;
      inf1       <= inf1_c;
      inf2       <= inf2_c;
      swapped    <= swap_c;
      sign_big   <= swap_c ? sign2_c : fa.sign;
      exp_big    <= exp_big_c;
      mant_big   <= sig_big_c;
      mant_small <= {sig_small_c, 3'b000};
    end else if (state == ALIGN) begin
      n          <= n_after_c;
      mant_small <= shift_c;
    end
  end

endmodule

// File: tb/tb_fp_unpack_align_r4.sv
// Directed vector bench for fp_unpack_align_r4 with backpressure and reset cases.
module tb_fp_unpack_align_r4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic        sign1, sign2, nan, invalid, inf1, inf2, swapped, sign_big;
  logic [7:0]  exp_big;
  logic [23:0] mant_big;
  logic [26:0] mant_small;

  int checks = 0;
  int errors = 0;

  fp_unpack_align_r4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign1      (sign1),
    .sign2      (sign2),
    .nan        (nan),
    .invalid    (invalid),
    .inf1       (inf1),
    .inf2       (inf2),
    .swapped    (swapped),
    .sign_big   (sign_big),
    .exp_big    (exp_big),
    .mant_big   (mant_big),
    .mant_small (mant_small)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [7:0]  flags;  // {sign1, sign2, nan, invalid, inf1, inf2, swapped, sign_big}
    logic [7:0]  eb;
    logic [23:0] mb;
    logic [26:0] ms;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Accepts one operand pair, measures latency and compares every output field.
  task automatic run_vec(input int idx, input vec_t v, input bit release_out);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
    op_a = v.a; op_b = v.b; sub = v.sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d flags", idx),
        32'({sign1, sign2, nan, invalid, inf1, inf2, swapped, sign_big}), 32'(v.flags));
    chk($sformatf("v%0d exp_big", idx), 32'(exp_big), 32'(v.eb));
    chk($sformatf("v%0d mant_big", idx), 32'(mant_big), 32'(v.mb));
    chk($sformatf("v%0d mant_small", idx), 32'(mant_small), 32'(v.ms));
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d idle after done", idx), 32'({in_ready, out_valid}), 32'b10);
    end
  endtask

  initial begin
    bit seen_valid;
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 8'b00000000, 8'h7F, 24'h800000, 27'h4000000, 1};
    vecs[1]  = '{32'h3F800000, 32'h40800000, 1'b0, 8'b00000010, 8'h81, 24'h800000, 27'h1000000, 2};
    vecs[2]  = '{32'h4B800000, 32'h3F800001, 1'b0, 8'b00000000, 8'h97, 24'h800000, 27'h0000005, 13};
    vecs[3]  = '{32'h7F000000, 32'h3F800000, 1'b0, 8'b00000000, 8'hFE, 24'h800000, 27'h0000001, 14};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b0, 8'b00110000, 8'hFF, 24'h800001, 27'h4000000, 1};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 8'b01011100, 8'hFF, 24'h800000, 27'h4000000, 1};
    vecs[6]  = '{32'h00000000, 32'h00000000, 1'b0, 8'b00000000, 8'h01, 24'h000000, 27'h0000000, 1};
    vecs[7]  = '{32'hC0000000, 32'h3F800000, 1'b1, 8'b11000001, 8'h80, 24'h800000, 27'h2000000, 2};
    vecs[8]  = '{32'h3F800000, 32'h7FC00000, 1'b0, 8'b00100010, 8'hFF, 24'hC00000, 27'h4000000, 1};
    vecs[9]  = '{32'h00800000, 32'h00000001, 1'b0, 8'b00000000, 8'h01, 24'h800000, 27'h0000008, 1};
    vecs[10] = '{32'h41000000, 32'h3FC00000, 1'b0, 8'b00000000, 8'h82, 24'h800000, 27'h0C00000, 3};
    vecs[11] = '{32'h3F800000, 32'hFF800000, 1'b0, 8'b01000111, 8'hFF, 24'h800000, 27'h4000000, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0;
    #2;
    chk("reset handshake", 32'({in_ready, out_valid}), 32'b10);
    chk("reset mant_small", 32'(mant_small), 32'd0);
    chk("reset exp/mant_big", 32'({exp_big, mant_big}), 32'd0);
    chk("reset flags", 32'({sign1, sign2, nan, invalid, inf1, inf2, swapped, sign_big}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i], 1'b1);
    end

    // Backpressure: hold DONE for five cycles while a new operand is offered.
    run_vec(100, vecs[1], 1'b0);
    op_a = 32'h40000000; op_b = 32'h3F800000; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d handshake", c), 32'({in_ready, out_valid}), 32'b01);
      chk($sformatf("bp%0d mant_small", c), 32'(mant_small), 32'h1000000);
      chk($sformatf("bp%0d exp/swap", c), 32'({exp_big, swapped}), {23'd0, 8'h81, 1'b1});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done exit idle", 32'({in_ready, out_valid}), 32'b10);
    in_valid = 1'b0;
    @(negedge clk);
    chk("no accept on exit", 32'({in_ready, out_valid}), 32'b10);

    // Reset during ALIGN discards the operation.
    @(negedge clk);
    op_a = 32'h7F000000; op_b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid-align busy", 32'({in_ready, out_valid}), 32'b00);
    rst_n = 1'b0;
    #1;
    chk("align reset handshake", 32'({in_ready, out_valid}), 32'b10);
    chk("align reset data", 32'({exp_big, mant_small[23:0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen_valid = 1'b1;
    end
    chk("no result after reset", 32'(seen_valid), 32'd0);
    run_vec(200, vecs[2], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
